// File: rtl/mem_stage_if.sv
// Execute-to-memory handshake, data-SRAM response, writeback handshake and decode
// forwarding bundle for the memory-access stage.
interface mem_stage_if #(
    parameter int SIDE_WD = 96
);
    logic               es_to_ms_valid;
    logic               ms_allowin;
    logic [31:0]        es_pc;
    logic [31:0]        es_result;
    logic [4:0]         es_dest;
    logic               es_gr_we;
    logic               es_res_from_mem;
    logic               es_mem_req;
    logic [4:0]         es_load_op;
    logic [1:0]         es_vaddr_lo;
    logic               es_ex;
    logic               es_csr_we;
    logic [4:0]         es_tlb_op;
    logic [SIDE_WD-1:0] es_side;
    logic               es_req_accepted;
    logic               data_sram_data_ok;
    logic [31:0]        data_sram_rdata;
    logic               flush;
    logic               ws_allowin;
    logic               ms_to_ws_valid;
    logic [31:0]        ms_pc;
    logic [31:0]        ms_final_result;
    logic [4:0]         ms_dest;
    logic               ms_gr_we;
    logic [SIDE_WD-1:0] ms_side_out;
    logic               ms_fwd_valid;
    logic               ms_blk_valid;
    logic [4:0]         ms_fwd_dest;
    logic [31:0]        ms_fwd_result;
    logic               ms_ex;
    logic               ms_tlb_blk;

    modport master (
        output es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_res_from_mem,
               es_mem_req, es_load_op, es_vaddr_lo, es_ex, es_csr_we, es_tlb_op, es_side,
               es_req_accepted, data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest, ms_gr_we,
               ms_side_out, ms_fwd_valid, ms_blk_valid, ms_fwd_dest, ms_fwd_result,
               ms_ex, ms_tlb_blk
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_result, es_dest, es_gr_we, es_res_from_mem,
               es_mem_req, es_load_op, es_vaddr_lo, es_ex, es_csr_we, es_tlb_op, es_side,
               es_req_accepted, data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest, ms_gr_we,
               ms_side_out, ms_fwd_valid, ms_blk_valid, ms_fwd_dest, ms_fwd_result,
               ms_ex, ms_tlb_blk
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, buffers it across
// writeback stalls, extends load data and drops responses orphaned by a flush.
module mem_stage #(
    parameter int SIDE_WD = 96
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);
    logic               ms_valid_q, ms_valid_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        result_q, result_d;
    logic [4:0]         dest_q, dest_d;
    logic               gr_we_q, gr_we_d;
    logic               res_from_mem_q, res_from_mem_d;
    logic               mem_req_q, mem_req_d;
    logic [4:0]         load_op_q, load_op_d;
    logic [1:0]         vaddr_lo_q, vaddr_lo_d;
    logic               ex_q, ex_d;
    logic               csr_we_q, csr_we_d;
    logic [4:0]         tlb_op_q, tlb_op_d;
    logic [SIDE_WD-1:0] side_q, side_d;
    logic               data_ok_seen_q, data_ok_seen_d;
    logic [31:0]        rdata_buf_q, rdata_buf_d;
    logic [1:0]         cancel_cnt_q, cancel_cnt_d;

    logic        ms_ready_go;
    logic        ms_allowin;
    logic        ms_to_ws_valid;
    logic        owned_ok;
    logic        leaving;
    logic        orphan_ms;
    logic        drop_ok;
    logic [2:0]  cnt_sum;
    logic [31:0] load_word;
    logic [31:0] load_ext;
    logic [31:0] final_result;
    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // A response with nothing pending cancellation belongs to the resident instruction.
    assign owned_ok    = bus.data_sram_data_ok && (cancel_cnt_q == 2'd0) && ms_valid_q
                         && mem_req_q && !ex_q && !data_ok_seen_q;
    assign ms_ready_go = !mem_req_q || ex_q || data_ok_seen_q
                         || (bus.data_sram_data_ok && (cancel_cnt_q == 2'd0));
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && bus.ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !bus.flush;
    assign leaving        = ms_to_ws_valid && bus.ws_allowin;
    assign orphan_ms      = ms_valid_q && mem_req_q && !ex_q && !data_ok_seen_q && !owned_ok;
    assign drop_ok        = bus.data_sram_data_ok && (cancel_cnt_q != 2'd0);

    assign load_word = data_ok_seen_q ? rdata_buf_q : bus.data_sram_rdata;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
        assign byte_lane[gi] = load_word[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
        assign half_lane[gi] = load_word[16*gi +: 16];
    end
    assign byte_v = byte_lane[vaddr_lo_q];
    assign half_v = half_lane[vaddr_lo_q[1]];

    // load_op is one-hot {ld_hu, ld_bu, ld_w, ld_h, ld_b}.
    always_comb begin
        load_ext = load_word;
        if (load_op_q[0])      load_ext = {{24{byte_v[7]}}, byte_v};
        else if (load_op_q[1]) load_ext = {{16{half_v[15]}}, half_v};
        else if (load_op_q[2]) load_ext = load_word;
        else if (load_op_q[3]) load_ext = {24'd0, byte_v};
        else if (load_op_q[4]) load_ext = {16'd0, half_v};
    end

    assign final_result = res_from_mem_q ? load_ext : result_q;

    always_comb begin
        ms_valid_d     = ms_valid_q;
        pc_d           = pc_q;
        result_d       = result_q;
        dest_d         = dest_q;
        gr_we_d        = gr_we_q;
        res_from_mem_d = res_from_mem_q;
        mem_req_d      = mem_req_q;
        load_op_d      = load_op_q;
        vaddr_lo_d     = vaddr_lo_q;
        ex_d           = ex_q;
        csr_we_d       = csr_we_q;
        tlb_op_d       = tlb_op_q;
        side_d         = side_q;
        data_ok_seen_d = data_ok_seen_q;
        rdata_buf_d    = rdata_buf_q;

        if (bus.flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = bus.es_to_ms_valid;
        end

        if (!bus.flush && ms_allowin && bus.es_to_ms_valid) begin
            pc_d           = bus.es_pc;
            result_d       = bus.es_result;
            dest_d         = bus.es_dest;
            gr_we_d        = bus.es_gr_we;
            res_from_mem_d = bus.es_res_from_mem;
            mem_req_d      = bus.es_mem_req;
            load_op_d      = bus.es_load_op;
            vaddr_lo_d     = bus.es_vaddr_lo;
            ex_d           = bus.es_ex;
            csr_we_d       = bus.es_csr_we;
            tlb_op_d       = bus.es_tlb_op;
            side_d         = bus.es_side;
        end

        // Hold the response if writeback cannot take it this cycle.
        if (bus.flush || leaving) begin
            data_ok_seen_d = 1'b0;
        end else if (owned_ok && !bus.ws_allowin) begin
            data_ok_seen_d = 1'b1;
            rdata_buf_d    = bus.data_sram_rdata;
        end
    end

    always_comb begin
        cnt_sum = {1'b0, cancel_cnt_q};
        if (bus.flush && orphan_ms)           cnt_sum = cnt_sum + 3'd1;
        if (bus.flush && bus.es_req_accepted) cnt_sum = cnt_sum + 3'd1;
        if (drop_ok)                          cnt_sum = cnt_sum - 3'd1;
        cancel_cnt_d = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q     <= 1'b0;
            pc_q           <= '0;
            result_q       <= '0;
            dest_q         <= '0;
            gr_we_q        <= 1'b0;
            res_from_mem_q <= 1'b0;
            mem_req_q      <= 1'b0;
            load_op_q      <= '0;
            vaddr_lo_q     <= '0;
            ex_q           <= 1'b0;
            csr_we_q       <= 1'b0;
            tlb_op_q       <= '0;
            side_q         <= '0;
            data_ok_seen_q <= 1'b0;
            rdata_buf_q    <= '0;
            cancel_cnt_q   <= '0;
        end else begin
            ms_valid_q     <= ms_valid_d;
            pc_q           <= pc_d;
            result_q       <= result_d;
            dest_q         <= dest_d;
            gr_we_q        <= gr_we_d;
            res_from_mem_q <= res_from_mem_d;
            mem_req_q      <= mem_req_d;
            load_op_q      <= load_op_d;
            vaddr_lo_q     <= vaddr_lo_d;
            ex_q           <= ex_d;
            csr_we_q       <= csr_we_d;
            tlb_op_q       <= tlb_op_d;
            side_q         <= side_d;
            data_ok_seen_q <= data_ok_seen_d;
            rdata_buf_q    <= rdata_buf_d;
            cancel_cnt_q   <= cancel_cnt_d;
        end
    end

    assign bus.ms_allowin      = ms_allowin;
    assign bus.ms_to_ws_valid  = ms_to_ws_valid;
    assign bus.ms_pc           = pc_q;
    assign bus.ms_final_result = final_result;
    assign bus.ms_dest         = dest_q;
    assign bus.ms_gr_we        = gr_we_q;
    assign bus.ms_side_out     = side_q;
    assign bus.ms_fwd_valid    = ms_valid_q && gr_we_q;
    assign bus.ms_blk_valid    = ms_valid_q && res_from_mem_q && !ms_ready_go;
    assign bus.ms_fwd_dest     = dest_q;
    assign bus.ms_fwd_result   = final_result;
    assign bus.ms_ex           = ms_valid_q && ex_q;
    // Only tlbrd (bit 1) of the one-hot TLB op blocks a younger tlbsrch.
    assign bus.ms_tlb_blk      = ms_valid_q && (((tlb_op_q & 5'b00010) != 5'd0) || csr_we_q);
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected writeback records, a
// negedge monitor pops and compares each accepted ms_to_ws transfer.
module tb_mem_stage;
    localparam int SIDE_WD = 96;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    typedef struct {
        logic [31:0]        pc;
        logic [31:0]        res;
        logic [4:0]         dest;
        logic               gr_we;
        logic [SIDE_WD-1:0] side;
    } exp_t;

    exp_t sb[$];

    mem_stage_if #(.SIDE_WD(SIDE_WD)) bus ();

    mem_stage #(.SIDE_WD(SIDE_WD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted transfer must match the oldest expected record.
    always @(negedge clk) begin
        if (!reset && bus.ms_to_ws_valid && bus.ws_allowin) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got pc %08h want no transfer", bus.ms_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_pc", bus.ms_pc, e.pc);
                chk("out_result", bus.ms_final_result, e.res);
                chk("out_dest", {27'd0, bus.ms_dest}, {27'd0, e.dest});
                chk("out_gr_we", {31'd0, bus.ms_gr_we}, {31'd0, e.gr_we});
                total++;
                if (bus.ms_side_out !== e.side) begin
                    bad++;
                    $display("FAIL out_side: got %024h want %024h", bus.ms_side_out, e.side);
                end
                $display("xfer pc=%08h result=%08h dest=%0d", bus.ms_pc, bus.ms_final_result, bus.ms_dest);
            end
        end
    end

    task automatic issue(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                         input logic gr_we, input logic rfm, input logic mreq,
                         input logic [4:0] lop, input logic [1:0] vlo, input logic ex,
                         input logic csr, input logic [4:0] tlb, input logic push,
                         input logic [31:0] exp_res);
        exp_t e;
        bus.es_pc           = pc;
        bus.es_result       = res;
        bus.es_dest         = dest;
        bus.es_gr_we        = gr_we;
        bus.es_res_from_mem = rfm;
        bus.es_mem_req      = mreq;
        bus.es_load_op      = lop;
        bus.es_vaddr_lo     = vlo;
        bus.es_ex           = ex;
        bus.es_csr_we       = csr;
        bus.es_tlb_op       = tlb;
        bus.es_side         = {pc, ~pc, pc};
        bus.es_to_ms_valid  = 1'b1;
        if (push) begin
            e.pc    = pc;
            e.res   = exp_res;
            e.dest  = dest;
            e.gr_we = gr_we;
            e.side  = {pc, ~pc, pc};
            sb.push_back(e);
        end
        tick();
        bus.es_to_ms_valid = 1'b0;
    endtask

    localparam logic [4:0] LD_B  = 5'b00001;
    localparam logic [4:0] LD_H  = 5'b00010;
    localparam logic [4:0] LD_W  = 5'b00100;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_HU = 5'b10000;

    logic [4:0]  tbl_op  [7];
    logic [1:0]  tbl_vlo [7];
    logic [31:0] tbl_exp [7];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.es_to_ms_valid    = 1'b0;
        bus.es_pc             = '0;
        bus.es_result         = '0;
        bus.es_dest           = '0;
        bus.es_gr_we          = 1'b0;
        bus.es_res_from_mem   = 1'b0;
        bus.es_mem_req        = 1'b0;
        bus.es_load_op        = '0;
        bus.es_vaddr_lo       = '0;
        bus.es_ex             = 1'b0;
        bus.es_csr_we         = 1'b0;
        bus.es_tlb_op         = '0;
        bus.es_side           = '0;
        bus.es_req_accepted   = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = '0;
        bus.flush             = 1'b0;
        bus.ws_allowin        = 1'b1;

        tbl_op[0] = LD_B;  tbl_vlo[0] = 2'd3; tbl_exp[0] = 32'hFFFF_FF80;
        tbl_op[1] = LD_BU; tbl_vlo[1] = 2'd3; tbl_exp[1] = 32'h0000_0080;
        tbl_op[2] = LD_H;  tbl_vlo[2] = 2'd2; tbl_exp[2] = 32'hFFFF_8012;
        tbl_op[3] = LD_HU; tbl_vlo[3] = 2'd2; tbl_exp[3] = 32'h0000_8012;
        tbl_op[4] = LD_B;  tbl_vlo[4] = 2'd0; tbl_exp[4] = 32'h0000_0056;
        tbl_op[5] = LD_H;  tbl_vlo[5] = 2'd0; tbl_exp[5] = 32'h0000_3456;
        tbl_op[6] = LD_W;  tbl_vlo[6] = 2'd1; tbl_exp[6] = 32'h8012_3456;

        // Reset state.
        tick();
        tick();
        chk("rst_allowin", {31'd0, bus.ms_allowin}, 32'd1);
        chk("rst_to_ws", {31'd0, bus.ms_to_ws_valid}, 32'd0);
        chk("rst_pc", bus.ms_pc, 32'd0);
        chk("rst_result", bus.ms_final_result, 32'd0);
        chk("rst_blk", {31'd0, bus.ms_blk_valid}, 32'd0);
        chk("rst_tlb_blk", {31'd0, bus.ms_tlb_blk}, 32'd0);
        reset = 1'b0;
        tick();

        // ld_w, response one cycle after entry.
        issue(32'h0000_1000, 32'h0000_0100, 5'd5, 1'b1, 1'b1, 1'b1, LD_W, 2'd0, 1'b0, 1'b0, 5'd0,
              1'b1, 32'h89AB_CDEF);
        #1;
        chk("ldw_blk_wait", {31'd0, bus.ms_blk_valid}, 32'd1);
        chk("ldw_to_ws_wait", {31'd0, bus.ms_to_ws_valid}, 32'd0);
        chk("ldw_fwd_valid", {31'd0, bus.ms_fwd_valid}, 32'd1);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h89AB_CDEF;
        #1;
        chk("ldw_to_ws", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        chk("ldw_fwd_result", bus.ms_fwd_result, 32'h89AB_CDEF);
        tick();
        bus.data_sram_data_ok = 1'b0;
        #1;
        chk("ldw_empty", {31'd0, bus.ms_to_ws_valid}, 32'd0);

        // Back-to-back extension loads, each response arriving as the next enters.
        bus.data_sram_rdata = 32'h8012_3456;
        for (int i = 0; i < 7; i++) begin
            bus.data_sram_data_ok = (i != 0);
            #1;
            if (i != 0) chk("b2b_allowin", {31'd0, bus.ms_allowin}, 32'd1);
            issue(32'h0000_1100 + 32'(i * 4), 32'h0000_0200, 5'd6, 1'b1, 1'b1, 1'b1,
                  tbl_op[i], tbl_vlo[i], 1'b0, 1'b0, 5'd0, 1'b1, tbl_exp[i]);
        end
        bus.data_sram_data_ok = 1'b1;
        #1;
        chk("b2b_last_to_ws", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        tick();
        bus.data_sram_data_ok = 1'b0;

        // Non-memory op with a CSR write: immediately ready, blocks tlbsrch.
        issue(32'h0000_1200, 32'h1234_5678, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 5'd0,
              1'b1, 32'h1234_5678);
        #1;
        chk("alu_to_ws", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        chk("csr_tlb_blk", {31'd0, bus.ms_tlb_blk}, 32'd1);
        tick();

        // Response during a writeback stall is buffered; bus data changes afterwards.
        issue(32'h0000_2000, 32'h0, 5'd8, 1'b1, 1'b1, 1'b1, LD_W, 2'd0, 1'b0, 1'b0, 5'd0,
              1'b1, 32'h1122_3344);
        bus.ws_allowin        = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h1122_3344;
        #1;
        chk("stall_allowin", {31'd0, bus.ms_allowin}, 32'd0);
        tick();
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("stall_blk", {31'd0, bus.ms_blk_valid}, 32'd0);
        chk("stall_held", bus.ms_final_result, 32'h1122_3344);
        bus.ws_allowin = 1'b1;
        tick();
        chk("stall_no_dup", {31'd0, bus.ms_to_ws_valid}, 32'd0);

        // Flush with an outstanding load plus a newly accepted request: two drops.
        issue(32'h0000_3000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, LD_W, 2'd0, 1'b0, 1'b0, 5'd0,
              1'b0, 32'h0);
        bus.flush           = 1'b1;
        bus.es_req_accepted = 1'b1;
        #1;
        chk("flush_to_ws", {31'd0, bus.ms_to_ws_valid}, 32'd0);
        tick();
        bus.flush           = 1'b0;
        bus.es_req_accepted = 1'b0;
        issue(32'h0000_3004, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, LD_W, 2'd0, 1'b0, 1'b0, 5'd0,
              1'b1, 32'hCAFE_F00D);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'hBAD0_0001;
        #1;
        chk("cancel_drop1", {31'd0, bus.ms_to_ws_valid}, 32'd0);
        chk("cancel_blk1", {31'd0, bus.ms_blk_valid}, 32'd1);
        tick();
        bus.data_sram_rdata = 32'hBAD0_0002;
        #1;
        chk("cancel_drop2", {31'd0, bus.ms_to_ws_valid}, 32'd0);
        tick();
        bus.data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("cancel_third", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        tick();
        bus.data_sram_data_ok = 1'b0;

        // Load with an exception already flagged: ready at once, stray response ignored.
        issue(32'h0000_5000, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, LD_W, 2'd0, 1'b1, 1'b0, 5'd0,
              1'b1, 32'h0000_BEEF);
        bus.ws_allowin        = 1'b0;
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h1212_1212;
        #1;
        chk("ex_flag", {31'd0, bus.ms_ex}, 32'd1);
        chk("ex_ready", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        tick();
        bus.data_sram_data_ok = 1'b0;
        bus.ws_allowin        = 1'b1;
        tick();
        issue(32'h0000_5004, 32'h0, 5'd11, 1'b1, 1'b1, 1'b1, LD_W, 2'd0, 1'b0, 1'b0, 5'd0,
              1'b1, 32'h0F0F_0F0F);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h0F0F_0F0F;
        #1;
        chk("ex_cnt_clean", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        tick();
        bus.data_sram_data_ok = 1'b0;

        // tlbrd blocks until it leaves.
        issue(32'h0000_6000, 32'h0000_0066, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0,
              5'b00010, 1'b1, 32'h0000_0066);
        bus.ws_allowin = 1'b0;
        #1;
        chk("tlbrd_blk1", {31'd0, bus.ms_tlb_blk}, 32'd1);
        tick();
        chk("tlbrd_blk2", {31'd0, bus.ms_tlb_blk}, 32'd1);
        bus.ws_allowin = 1'b1;
        tick();
        chk("tlbrd_gone", {31'd0, bus.ms_tlb_blk}, 32'd0);

        // Build up cancellations, then reset asynchronously while a load waits.
        issue(32'h0000_6100, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, LD_W, 2'd0, 1'b0, 1'b0, 5'd0,
              1'b0, 32'h0);
        bus.flush           = 1'b1;
        bus.es_req_accepted = 1'b1;
        tick();
        bus.flush           = 1'b0;
        bus.es_req_accepted = 1'b0;
        issue(32'h0000_6104, 32'h0, 5'd13, 1'b1, 1'b1, 1'b1, LD_W, 2'd0, 1'b0, 1'b0, 5'd0,
              1'b0, 32'h0);
        #1;
        chk("pre_rst_blk", {31'd0, bus.ms_blk_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_allowin", {31'd0, bus.ms_allowin}, 32'd1);
        chk("arst_blk", {31'd0, bus.ms_blk_valid}, 32'd0);
        chk("arst_fwd_valid", {31'd0, bus.ms_fwd_valid}, 32'd0);
        chk("arst_pc", bus.ms_pc, 32'd0);
        chk("arst_dest", {27'd0, bus.ms_dest}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        issue(32'h0000_7000, 32'h0, 5'd14, 1'b1, 1'b1, 1'b1, LD_W, 2'd0, 1'b0, 1'b0, 5'd0,
              1'b1, 32'h7777_7777);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h7777_7777;
        #1;
        chk("rst_cnt_clear", {31'd0, bus.ms_to_ws_valid}, 32'd1);
        tick();
        bus.data_sram_data_ok = 1'b0;
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
